// File: rtl/memory_be.sv
// -----------------------------------------------------------------------------
// memory_be
//   Single-port word memory with byte-lane write enables and a configurable
//   read latency. Writes complete at the accept edge. A read with READ_LAT > 1
//   holds off new requests until its response has been issued. Any access at
//   or above DEPTH does not touch the memory and raises err_o. For a read, err_o
//   is raised together with rvalid_o and the returned data is zero.
//
// Parameters
//   DEPTH      : number of words (>= 2, any value)
//   WIDTH      : word width in bits (multiple of 8)
//   ADDR_WIDTH : address width
//   READ_LAT   : read latency in cycles (1..4)
//   NBYTES     : number of byte lanes
//
// Ports
//   clk_i    : clock, rising edge
//   rst_i    : synchronous active-high reset; clears the memory and all outputs
//   valid_i  : request valid; accepted when valid_i && ready_o
//   wr_rd_i  : 1 = write, 0 = read
//   addr_i   : word address
//   wdata_i  : write data
//   be_i     : byte enables, bit n covers bits [8n+7:8n]
//   ready_o  : able to accept a request
//   rvalid_o : one-cycle read-response strobe
//   rdata_o  : read data, held between responses
//   err_o    : one-cycle out-of-range strobe
// -----------------------------------------------------------------------------
module memory_be #(
    parameter int DEPTH      = 16,
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int READ_LAT   = 2,
    parameter int NBYTES     = WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic                  wr_rd_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic [NBYTES-1:0]     be_i,
    output logic                  ready_o,
    output logic                  rvalid_o,
    output logic [WIDTH-1:0]      rdata_o,
    output logic                  err_o
);

    typedef enum logic {
        IDLE,
        RD_WAIT
    } state_t;

    // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
    // Wait cycles remaining after the accept edge, minus the response edge.
    localparam logic [2:0] CNT_INIT = (READ_LAT > 1) ? 3'(READ_LAT - 2) : 3'd0;

    logic [WIDTH-1:0]      r_mem [DEPTH];
    state_t                r_state;
    state_t                w_state_nxt;
    logic [2:0]            r_cnt;
    logic [2:0]            w_cnt_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_ready;
    logic                  r_rvalid;
    logic                  r_err;
    logic [WIDTH-1:0]      r_rdata;

    logic                  w_accept;
    logic                  w_wr_in_range;
    logic                  w_respond;
    logic [ADDR_WIDTH-1:0] w_resp_addr;
    logic                  w_resp_in_range;
    logic [WIDTH-1:0]      w_resp_data;

    assign w_accept      = valid_i && r_ready;
    assign w_wr_in_range = ({1'b0, addr_i} < DEPTH_EXT);

    // Next-state logic. w_respond marks the edge at which a read response is
    // registered; w_resp_addr is the address that response is served from.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_respond   = 1'b0;
        w_resp_addr = addr_i;
        case (r_state)
            IDLE: begin
                if (w_accept && !wr_rd_i) begin
                    if (READ_LAT == 1) begin
                        w_respond = 1'b1;
                    end else begin
                        w_state_nxt = RD_WAIT;
                        w_cnt_nxt   = CNT_INIT;
                    end
                end
            end
            RD_WAIT: begin
                w_resp_addr = r_addr;
                if (r_cnt == 3'd0) begin
                    w_respond   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_resp_in_range = ({1'b0, w_resp_addr} < DEPTH_EXT);
    assign w_resp_data     = w_resp_in_range ? r_mem[w_resp_addr] : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_ready  <= 1'b0;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[ADDR_WIDTH'(i)] <= '0;
            end
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ready  <= (w_state_nxt == IDLE);
            r_rvalid <= w_respond;
            // A response and a write accept never share an edge, so the two
            // error sources are mutually exclusive.
            r_err    <= w_respond ? !w_resp_in_range
                                  : (w_accept && wr_rd_i && !w_wr_in_range);
            if (w_respond) begin
                r_rdata <= w_resp_data;
            end
            if (w_accept) begin
                r_addr <= addr_i;
            end
            if (w_accept && wr_rd_i && w_wr_in_range) begin
                for (int unsigned b = 0; b < NBYTES; b++) begin
                    if (be_i[b]) begin
                        r_mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end
        end
    end

    assign ready_o  = r_ready;
    assign rvalid_o = r_rvalid;
    assign rdata_o  = r_rdata;
    assign err_o    = r_err;

endmodule

// File: tb/tb_memory_be.sv
// -----------------------------------------------------------------------------
// tb_memory_be
//   Three memory_be instances (DEPTH=12, READ_LAT = 1, 2 and 4) share one
//   input stream. Each instance has its own transaction-level reference:
//   a word array plus at most one outstanding read, which is due
//   READ_LAT-1 edges after its accept edge. Outputs are compared on every
//   falling edge.
// -----------------------------------------------------------------------------
module tb_memory_be;

    localparam int DEPTH = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        wr_rd;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;

    logic [2:0]  rdy;
    logic [2:0]  rv;
    logic [2:0]  er;
    logic [31:0] rd [3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    memory_be #(.DEPTH(DEPTH), .WIDTH(32), .READ_LAT(1)) u_lat1 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .wr_rd_i(wr_rd), .addr_i(addr),
        .wdata_i(wdata), .be_i(be), .ready_o(rdy[0]), .rvalid_o(rv[0]),
        .rdata_o(rd[0]), .err_o(er[0]));

    memory_be #(.DEPTH(DEPTH), .WIDTH(32), .READ_LAT(2)) u_lat2 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .wr_rd_i(wr_rd), .addr_i(addr),
        .wdata_i(wdata), .be_i(be), .ready_o(rdy[1]), .rvalid_o(rv[1]),
        .rdata_o(rd[1]), .err_o(er[1]));

    memory_be #(.DEPTH(DEPTH), .WIDTH(32), .READ_LAT(4)) u_lat4 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .wr_rd_i(wr_rd), .addr_i(addr),
        .wdata_i(wdata), .be_i(be), .ready_o(rdy[2]), .rvalid_o(rv[2]),
        .rdata_o(rd[2]), .err_o(er[2]));

    // ---------------- reference model ----------------
    int          lats [3] = '{1, 2, 4};
    logic [31:0] m_mem [3][DEPTH];
    bit          m_ready  [3];
    bit          m_rvalid [3];
    bit          m_err    [3];
    logic [31:0] m_rdata  [3];
    bit          m_pend   [3];
    int          m_due    [3];
    logic [31:0] m_pdata  [3];
    bit          m_perr   [3];
    int          cyc = 0;

    always @(posedge clk) begin
        logic [31:0] mask;
        cyc = cyc + 1;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                for (int w = 0; w < DEPTH; w++) m_mem[k][w] = 32'h0;
                m_ready[k]  = 1'b0;
                m_rvalid[k] = 1'b0;
                m_err[k]    = 1'b0;
                m_rdata[k]  = 32'h0;
                m_pend[k]   = 1'b0;
            end else begin
                m_rvalid[k] = 1'b0;
                m_err[k]    = 1'b0;
                if (valid && m_ready[k]) begin
                    if (wr_rd) begin
                        if (int'(addr) < DEPTH)
                            m_mem[k][addr] = (m_mem[k][addr] & ~mask) | (wdata & mask);
                        else
                            m_err[k] = 1'b1;
                    end else begin
                        m_pend[k] = 1'b1;
                        m_due[k]  = cyc + lats[k] - 1;
                        if (int'(addr) < DEPTH) begin
                            m_pdata[k] = m_mem[k][addr];
                            m_perr[k]  = 1'b0;
                        end else begin
                            m_pdata[k] = 32'h0;
                            m_perr[k]  = 1'b1;
                        end
                    end
                end
                if (m_pend[k] && m_due[k] == cyc) begin
                    m_rvalid[k] = 1'b1;
                    m_rdata[k]  = m_pdata[k];
                    m_err[k]    = m_perr[k];
                    m_pend[k]   = 1'b0;
                end
                m_ready[k] = !m_pend[k];
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("L%0d ready", lats[k]),  {31'b0, rdy[k]}, {31'b0, m_ready[k]});
            check_eq($sformatf("L%0d rvalid", lats[k]), {31'b0, rv[k]},  {31'b0, m_rvalid[k]});
            check_eq($sformatf("L%0d err", lats[k]),    {31'b0, er[k]},  {31'b0, m_err[k]});
            check_eq($sformatf("L%0d rdata", lats[k]),  rd[k],           m_rdata[k]);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic req(input logic wr, input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
        valid = 1'b1;
        wr_rd = wr;
        addr  = a;
        wdata = d;
        be    = b;
        tick();
        valid = 1'b0;
    endtask

    task automatic check_all_rdata(input string tag, input logic [31:0] exp);
        for (int k = 0; k < 3; k++)
            check_eq($sformatf("L%0d %s", lats[k], tag), rd[k], exp);
    endtask

    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        wr_rd = 1'b0;
        addr  = '0;
        wdata = '0;
        be    = '0;
        idle(2);
        rst = 1'b0;
        idle(1);

        // Full-word write then read back.
        req(1'b1, 4'd3, 32'hDEADBEEF, 4'b1111);
        req(1'b0, 4'd3, 32'h0, 4'b0000);
        idle(4);
        check_all_rdata("rd3", 32'hDEADBEEF);

        // Partial byte-lane overwrite and an all-lanes-off write.
        req(1'b1, 4'd5, 32'hFFFFFFFF, 4'b1111);
        req(1'b1, 4'd5, 32'h00000000, 4'b0101);
        req(1'b1, 4'd5, 32'h12345678, 4'b0000);
        req(1'b0, 4'd5, 32'h0, 4'b0000);
        idle(4);
        check_all_rdata("rd5", 32'hFF00FF00);

        // Out-of-range write and read, plus the last valid word.
        req(1'b1, 4'd13, 32'hA5A5A5A5, 4'b1111);
        req(1'b1, 4'd11, 32'hCAFEF00D, 4'b1111);
        req(1'b1, 4'd12, 32'h11111111, 4'b1111);
        req(1'b0, 4'd13, 32'h0, 4'b0000);
        idle(4);
        check_all_rdata("rd13", 32'h0);
        req(1'b0, 4'd11, 32'h0, 4'b0000);
        idle(4);
        check_all_rdata("rd11", 32'hCAFEF00D);

        // Back-to-back reads of 0..3.
        for (int a = 0; a < 4; a++) req(1'b0, 4'(a), 32'h0, 4'b0000);
        idle(4);

        // valid held through the wait window with a different address.
        req(1'b0, 4'd3, 32'h0, 4'b0000);
        valid = 1'b1; wr_rd = 1'b0; addr = 4'd5;
        idle(3);
        valid = 1'b0;
        idle(4);

        // Reset pulsed two cycles after a read accept.
        req(1'b0, 4'd3, 32'h0, 4'b0000);
        idle(1);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(2);
        req(1'b0, 4'd3, 32'h0, 4'b0000);
        idle(4);
        check_all_rdata("rd3 after rst", 32'h0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom_range(63) == 0);
            valid = $urandom_range(1);
            wr_rd = $urandom_range(1);
            addr  = 4'($urandom_range(15));
            wdata = $urandom;
            be    = 4'($urandom_range(15));
            tick();
        end
        rst   = 1'b0;
        valid = 1'b0;
        idle(5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/memory_be.md
MEMORY_BE -- requirements
Module: memory_be

Interface
REQ-001 SHALL have parameter DEPTH, default 16: number of words; any value >= 2, not necessarily a power of two.
REQ-002 SHALL have parameter WIDTH, default 32: word width in bits; multiple of 8.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(DEPTH): address width.
REQ-004 SHALL have parameter READ_LAT, default 2: read latency in cycles, legal range 1..4.
REQ-005 SHALL have parameter NBYTES, default WIDTH/8: number of byte lanes.
REQ-006 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port valid_i, input, 1 bit: request valid.
REQ-009 SHALL have port wr_rd_i, input, 1 bit: 1 = write, 0 = read.
REQ-010 SHALL have port addr_i, input, ADDR_WIDTH bits: word address.
REQ-011 SHALL have port wdata_i, input, WIDTH bits: write data.
REQ-012 SHALL have port be_i, input, NBYTES bits: byte enables; bit n enables bits [8n+7:8n].
REQ-013 SHALL have port ready_o, output, 1 bit: request accepted when valid_i && ready_o at a rising edge.
REQ-014 SHALL have port rvalid_o, output, 1 bit: one-cycle read-response strobe.
REQ-015 SHALL have port rdata_o, output, WIDTH bits: read data.
REQ-016 SHALL have port err_o, output, 1 bit: one-cycle strobe for an out-of-range access.

Function
REQ-017 SHALL implement FSM states IDLE (ready_o=1) and RD_WAIT (ready_o=0, latency counter running).
REQ-018 SHALL complete an accepted in-range write at the accept edge: only lanes with be_i[n]=1 update; be_i=0 leaves the word unchanged; FSM stays IDLE.
REQ-019 SHALL, on an accepted read at edge E0 with READ_LAT=1, drive rvalid_o=1 and rdata_o=mem[addr_i] in the cycle after E0, with ready_o staying 1 (one read per cycle).
REQ-020 SHALL, on an accepted read at edge E0 with READ_LAT>1, enter RD_WAIT, hold ready_o=0 for READ_LAT-1 cycles, and assert rvalid_o with data in the cycle after edge E0+READ_LAT-1, returning to IDLE at that edge.
REQ-021 SHALL latch the read address at acceptance, so addr_i changes during RD_WAIT have no effect.
REQ-022 SHALL return the post-write value for a read of a word written on an earlier edge.
REQ-023 SHALL hold rdata_o at its last read value while rvalid_o=0.
REQ-024 SHALL treat addr_i >= DEPTH as out of range: no memory change, err_o=1 for one cycle aligned with where the response would be (next cycle for writes, the rvalid_o cycle for reads), and a read returns rdata_o=0 with rvalid_o=1.
REQ-025 SHALL ignore valid_i while ready_o=0; requests are not queued.
REQ-026 SHALL keep rvalid_o and err_o at 0 in every cycle without a corresponding response.

Reset
REQ-027 SHALL, while rst_i=1 at a rising edge, set ready_o=0, rvalid_o=0, err_o=0, rdata_o=0, FSM=IDLE, counter=0, and all DEPTH words to 0.
REQ-028 SHALL drive ready_o=1 in the first cycle after rst_i deasserts.
REQ-029 SHALL abort a reset asserted mid-read: no rvalid_o is produced for that read afterwards.
REQ-030 SHALL give rst_i priority over valid_i at the same edge.

Verification
REQ-031 SHALL cover: write 0xDEADBEEF to addr 3 with be_i=1111 -> read addr 3, READ_LAT=2 -> ready_o low 1 cycle, rvalid_o=1 two cycles after the accept edge, rdata_o=0xDEADBEEF.
REQ-032 SHALL cover: write 0xFFFFFFFF to addr 5, then write 0x00000000 with be_i=0101 -> read returns 0xFF00FF00.
REQ-033 SHALL cover: DEPTH=12 with a write to addr 13 -> err_o=1 one cycle, memory unchanged; read addr 13 -> rvalid_o=1, err_o=1, rdata_o=0.
REQ-034 SHALL cover: READ_LAT=1 with back-to-back reads of addr 0..3 on consecutive cycles -> four consecutive rvalid_o cycles, ready_o never 0.
REQ-035 SHALL cover: READ_LAT=4 with rst_i pulsed 2 cycles after a read accept -> no rvalid_o, all outputs 0 during reset, then a read of any address returns 0.
REQ-036 SHALL cover: valid_i held high during RD_WAIT with a different address -> that request is ignored, and exactly one response is produced, for the latched address.
